// File: rtl/debounce_sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer with async active-high reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/debounce.sv
// debounce: synchronizes a noisy input and changes q only after N agreeing samples.
module debounce #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic         ds;
  logic [N-1:0] sr_q, sr_d;
  logic         q_q, q_d;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(d), .q(ds));
  // Mixed sample history holds the previous settled level.
  always_comb begin
    sr_d = {sr_q[N-2:0], ds};
    q_d  = &sr_q ? 1'b1 : ~|sr_q ? 1'b0 : q_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr_q <= '0;
      q_q  <= 1'b0;
    end else begin
      sr_q <= sr_d;
      q_q  <= q_d;
    end
  assign q = q_q;
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed checks of debounce latency, glitch rejection and reset for N=3, 2 and 8.
module tb_debounce;
  logic clk = 1'b0, rst = 1'b0;
  logic d3 = 1'b0, d2 = 1'b0, d8 = 1'b0;
  logic q3, q2, q8;
  int errors = 0, checks = 0;

  debounce #(.N(3), .SYNC_STAGES(2)) dut3 (.clk(clk), .rst(rst), .d(d3), .q(q3));
  debounce #(.N(2), .SYNC_STAGES(2)) dut2 (.clk(clk), .rst(rst), .d(d2), .q(q2));
  debounce #(.N(8), .SYNC_STAGES(2)) dut8 (.clk(clk), .rst(rst), .d(d8), .q(q8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int s, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s (dut %0d): q=%b expected %b at %0t", tag, s, got, exp, $time);
    end
  endtask

  function automatic logic qsel(input int s);
    return (s == 0) ? q3 : (s == 1) ? q2 : q8;
  endfunction

  task automatic setd(input int s, input logic v);
    if (s == 0) d3 = v;
    else if (s == 1) d2 = v;
    else d8 = v;
  endtask

  task automatic edge_chk(input int s, input logic exp, input string tag);
    @(posedge clk);
    #1;
    chk(tag, s, qsel(s), exp);
  endtask

  // q must keep its old level for n+2 edges and take v on edge n+3.
  task automatic settle(input int s, input int n, input logic v, input string tag);
    setd(s, v);
    for (int k = 1; k <= n + 2; k++) edge_chk(s, ~v, tag);
    edge_chk(s, v, tag);
  endtask

  task automatic glitch(input int s, input int n, input logic v, input string tag);
    repeat (2) begin
      setd(s, ~v);
      repeat (n - 1) edge_chk(s, v, tag);
      setd(s, v);
      repeat (n - 1) edge_chk(s, v, tag);
    end
    repeat (n + 3) edge_chk(s, v, tag);
  endtask

  // Exactly-n-sample high pulse: q rises at edge n+3, falls at edge 2n+3.
  task automatic pulse(input int s, input int n);
    setd(s, 1'b1);
    for (int k = 1; k <= n + 2; k++) begin
      edge_chk(s, 1'b0, "pulse_wait");
      if (k == n) setd(s, 1'b0);
    end
    edge_chk(s, 1'b1, "pulse_rise");
    repeat (n - 1) edge_chk(s, 1'b1, "pulse_hold");
    edge_chk(s, 1'b0, "pulse_fall");
  endtask

  task automatic sweep(input int s, input int n);
    settle(s, n, 1'b1, "settle_hi");
    glitch(s, n, 1'b1, "glitch_lo");
    settle(s, n, 1'b0, "settle_lo");
    glitch(s, n, 1'b0, "glitch_hi");
    pulse(s, n);
  endtask

  initial begin
    d3 = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 0, q3, 1'b0);
    chk("async_rst", 1, q2, 1'b0);
    chk("async_rst", 2, q8, 1'b0);
    edge_chk(0, 1'b0, "rst_hold");
    edge_chk(0, 1'b0, "rst_hold");
    rst = 1'b0;
    sweep(0, 3);
    setd(0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    setd(0, 1'b1);
    repeat (3) edge_chk(0, 1'b0, "mid_fill");
    rst = 1'b1;
    #1;
    chk("mid_rst", 0, q3, 1'b0);
    edge_chk(0, 1'b0, "mid_rst_hold");
    rst = 1'b0;
    settle(0, 3, 1'b1, "mid_release");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_mid_cycle", 0, q3, 1'b0);
    edge_chk(0, 1'b0, "async_hold");
    rst = 1'b0;
    setd(0, 1'b0);
    sweep(1, 2);
    sweep(2, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Debounces one noisy, asynchronous single-bit input (push-button or switch) into a clean, glitch-free level `q`.
- Synchronizes `d` into the `clk` domain, then passes it through an N-deep sample shift register.
- `q` changes only when all N consecutive synchronized samples agree.
- Sits directly behind a board-level input pin, ahead of edge detectors and control logic.

Parameters:
- N, 4, number of consecutive identical samples required to change `q`; legal range 2..32 (benches use N=3).
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer; legal minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  1  raw, asynchronous, possibly bouncing input.
- q  output  1  debounced level, registered.

Behaviour:
- Reset:
  - While `rst`=1, all synchronizer flops, all shift-register bits and `q` are forced to 0 immediately, without waiting for a clock edge.
  - Reset release is taken on the next rising edge; no other reset behaviour.
- Synchronizer:
  - `sync[0]` <= d; `sync[i]` <= `sync[i-1]`.
  - `ds` = `sync[SYNC_STAGES-1]`.
- Shift register:
  - `sr[N-1:0]` <= {`sr[N-2:0]`, `ds`} on every rising edge; `sr[0]` holds the newest sample.
- Output register (updated every rising edge):
  - If `sr` is all ones, `q` <= 1.
  - Else if `sr` is all zeros, `q` <= 0.
  - Otherwise `q` holds its value.
- Latency:
  - Let `d` become stable before rising edge 1.
  - `q` takes the new value on rising edge SYNC_STAGES+N+1 (edge 6 for defaults SYNC_STAGES=2, N=3).
  - `q` is a flop output; it has no combinational path from `d`.
- Glitch rejection:
  - Any excursion of `d` lasting fewer than N synchronized samples never changes `q`.
  - An excursion of exactly N samples (clean, not resampled across an edge) does change `q`.
- Boundaries:
  - `d` bouncing indefinitely leaves `q` frozen at its last settled value.
  - `d`=1 held through reset release causes `q` to rise after the full latency; `q` does not start at 1.
  - `rst` asserted mid-transition clears any partially filled `sr`; counting restarts from zero after release.
  - Changing N changes only the depth and the all-ones/all-zeros compare width.
- No metastability-sensitive logic may read `sync[0]`.

Decomposition:
- No shared package needed. N and SYNC_STAGES are module parameters; there are no typedefs.
- One natural sub-module: `sync_ff` (parameterised SYNC_STAGES-deep single-bit synchronizer with asynchronous active-high reset).
- `debounce` instantiates `sync_ff`, then the shift register and the agree/hold output logic.

Test Plan:
- Reset:
  - Hold `rst`=1 for 2 cycles with `d`=1, then assert `rst` asynchronously mid-cycle later.
  - Required: `q`=0 and all state 0 immediately, without waiting for a clock edge.
- Settle high (N=3, SYNC_STAGES=2):
  - After reset release, hold `d`=1.
  - Required: `q` rises exactly on the 6th rising edge after `d` is stable, then stays 1.
- Short glitch rejected:
  - With `q`=1, drive `d`=0 for 2 cycles, then back to 1 for 2 cycles, repeated twice.
  - Required: `q` remains 1 throughout.
- Valid low accepted:
  - With `q`=1, drive `d`=0 for 5 cycles.
  - Required: `q` falls 6 edges after the first stable low edge.
  - Then 2-cycle high glitches are ignored and `q` stays 0.
- Mid-transition reset:
  - Drive `d`=1 for 3 cycles (`sr` partially full), assert `rst` for 1 cycle, keep `d`=1.
  - Required: `q` rises a full 6 edges after reset release, not earlier.
- Parameter sweep:
  - Repeat the settle-high and short-glitch checks for N=2 and N=8.
  - Required: latency is SYNC_STAGES+N+1 edges; N-1 sample glitches are rejected; N-sample pulses are accepted.
